// File: rtl/cache_fill_fsm.sv
// ============================================================================
// cache_fill_fsm : issues BLOCK_WORDS sequential word reads for a missed cache
//                  block and steers returned words into the data/tag arrays.
// Revision: 1.0
// ============================================================================
`default_nettype none

module cache_fill_fsm #(
  parameter int BLOCK_WORDS = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           miss_detected,
  input  logic [15:0]                    miss_address,
  input  logic [15:0]                    memory_data,
  input  logic                           memory_data_valid,
  output logic                           mem_en,
  output logic [15:0]                    memory_address,
  output logic                           fsm_busy,
  output logic                           write_data_array,
  output logic                           write_tag_array,
  output logic [$clog2(BLOCK_WORDS)-1:0] fill_word_idx,
  output logic [15:0]                    fill_data
);

  localparam int IDX_W = $clog2(BLOCK_WORDS);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] BLOCK_CNT = CNT_W'(BLOCK_WORDS);
  localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(BLOCK_WORDS - 1);
  localparam logic [15:0]      OFS_MASK  = 16'(2 * BLOCK_WORDS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] iss, iss_next;
  logic [CNT_W-1:0] rcv, rcv_next;
  logic [15:0]      base, base_next;
  logic             issue;
  logic             last_word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      iss   <= '0;
      rcv   <= '0;
      base  <= '0;
    end else begin
      state <= state_next;
      iss   <= iss_next;
      rcv   <= rcv_next;
      base  <= base_next;
    end
  end

  always_comb begin
    state_next       = state;
    iss_next         = iss;
    rcv_next         = rcv;
    base_next        = base;
    issue            = 1'b0;
    last_word        = 1'b0;
    fsm_busy         = 1'b0;
    write_data_array = 1'b0;
    write_tag_array  = 1'b0;
    case (state)
      IDLE: begin
        iss_next = '0;
        rcv_next = '0;
        if (miss_detected) begin
          state_next = FILL;
          base_next  = miss_address & ~OFS_MASK;
        end
      end
      FILL: begin
        fsm_busy         = 1'b1;
        issue            = (iss < BLOCK_CNT);
        write_data_array = memory_data_valid;
        last_word        = memory_data_valid && (rcv == LAST_IDX);
        write_tag_array  = last_word;
        if (issue) begin
          iss_next = iss + CNT_W'(1);
        end
        if (memory_data_valid) begin
          rcv_next = rcv + CNT_W'(1);
        end
        // Last word closes the fill; counters restart for the next miss.
        if (last_word) begin
          state_next = IDLE;
          iss_next   = '0;
          rcv_next   = '0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign mem_en         = issue;
  assign memory_address = base + {{(15 - CNT_W){1'b0}}, iss, 1'b0};
  assign fill_word_idx  = rcv[IDX_W-1:0];
  assign fill_data      = memory_data;

endmodule

`default_nettype wire
